// File: rtl/vga_scan_ctrl.sv
// Programmable VGA scan controller: timing counters, frame-memory address issue and
// sync/blank delay matched to the memory read latency, with a pixel clock-enable divider.
module vga_scan_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int RD_LAT   = 1,
    parameter int CLK_DIV  = 1,
    parameter int CW       = 8,
    parameter int AW       = 10
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            en,
    output logic            pix_ce,
    output logic            req,
    output logic [AW-1:0]   h_addr,
    output logic [AW-1:0]   v_addr,
    input  logic [3*CW-1:0] pix_data,
    output logic            hsync,
    output logic            vsync,
    output logic            valid,
    output logic [CW-1:0]   vga_r,
    output logic [CW-1:0]   vga_g,
    output logic [CW-1:0]   vga_b,
    output logic            frame_start,
    output logic            line_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);

    logic          clr;
    logic          run;
    logic [DW-1:0] div_cnt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          hs_p0;
    logic          vs_p0;
    logic          vld_al;
    logic          hs_al;
    logic          vs_al;

    // run is a registered copy of (resetn && en) so every output is blank for the
    // cycle in which reset or the enable drop is sampled, and restart begins at origin.
    assign clr    = !resetn || !en;
    assign pix_ce = run && (div_cnt == D_LAST);

    always_ff @(posedge clk) begin
        if (clr) begin
            run     <= 1'b0;
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            run <= 1'b1;
            if (run) begin
                div_cnt <= pix_ce ? '0 : div_cnt + 1'b1;
            end
            if (pix_ce) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    // Stage p0: address issue and raw sync levels, combinational from the counters
    always_comb begin
        req    = run && (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
        h_addr = req ? AW'(h_cnt) : '0;
        v_addr = req ? AW'(v_cnt) : '0;
        hs_p0  = run && (int'(h_cnt) >= HS_BEG) && (int'(h_cnt) < HS_END);
        vs_p0  = run && (int'(v_cnt) >= VS_BEG) && (int'(v_cnt) < VS_END);
    end

    assign line_start  = pix_ce && (h_cnt == '0);
    assign frame_start = line_start && (v_cnt == '0);

    // Alignment stages: control bits delayed RD_LAT ticks to meet the returned pixel
    generate
        if (RD_LAT == 0) begin : g_lat0
            assign vld_al = req;
            assign hs_al  = hs_p0;
            assign vs_al  = vs_p0;
        end else begin : g_lat
            logic vld_pd [RD_LAT];
            logic hs_pd  [RD_LAT];
            logic vs_pd  [RD_LAT];

            always_ff @(posedge clk) begin
                if (clr) begin
                    for (int i = 0; i < RD_LAT; i++) begin
                        vld_pd[i] <= 1'b0;
                        hs_pd[i]  <= 1'b0;
                        vs_pd[i]  <= 1'b0;
                    end
                end else if (pix_ce) begin
                    vld_pd[0] <= req;
                    hs_pd[0]  <= hs_p0;
                    vs_pd[0]  <= vs_p0;
                    for (int i = 1; i < RD_LAT; i++) begin
                        vld_pd[i] <= vld_pd[i-1];
                        hs_pd[i]  <= hs_pd[i-1];
                        vs_pd[i]  <= vs_pd[i-1];
                    end
                end
            end

            assign vld_al = vld_pd[RD_LAT-1];
            assign hs_al  = hs_pd[RD_LAT-1];
            assign vs_al  = vs_pd[RD_LAT-1];
        end
    endgenerate

    // Output stage: pins update only on pixel ticks
    always_ff @(posedge clk) begin
        if (clr) begin
            valid <= 1'b0;
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else if (pix_ce) begin
            valid <= vld_al;
            hsync <= ~(hs_al ^ HS_POL);
            vsync <= ~(vs_al ^ VS_POL);
            vga_r <= vld_al ? pix_data[3*CW-1 -: CW] : '0;
            vga_g <= vld_al ? pix_data[2*CW-1 -: CW] : '0;
            vga_b <= vld_al ? pix_data[CW-1:0]       : '0;
        end
    end

endmodule
